// File: rtl/gemm_icb_arbiter.sv
// ---------------------------------------------------------------------------
// gemm_icb_arbiter
//
// Purpose:
//   Shares the single NICE ICB memory port between the GEMM operand-fetch
//   path (read requester) and the result write-back path (write requester).
//   Commands are issued one at a time through a small grant FSM. A tag FIFO
//   records whether each in-flight transaction is a read or a write.
//   In-order responses are then steered back: read data goes to the fetch
//   side, and write acknowledges become a one-cycle wr_done pulse.
//
// Configuration macro:
//   GEMM_ARB_RR_EN  defined   -> round-robin; after a grant the other
//                                requester has priority.
//                   undefined -> fixed priority, write beats read.
//
// Parameters:
//   OUTSTD_DEPTH  max in-flight ICB transactions (power of 2, >= 2)
//   AW            address width
//   DW            data width
//
// Ports:
//   nice_clk, nice_rst_n         clock / async active-low reset
//   rd_req_*                     read request handshake (valid/ready/addr)
//   rd_rsp_*                     read response handshake (valid/ready/data)
//   wr_req_*                     write request handshake (valid/ready/addr/data)
//   wr_done                      one-cycle pulse per completed write response
//   nice_icb_cmd_*               ICB command channel
//   nice_icb_rsp_*               ICB response channel
//   nice_mem_holdup              command pending or transaction in flight
//   outstd_cnt                   in-flight transaction count
//   err_sticky / err_clr         sticky response-error flag and its clear
//
// Grant FSM:
//   state  | meaning
//   S_NONE | no command presented; arbitrates when there is room in flight
//   S_RD   | read command presented on ICB, held until cmd_ready
//   S_WR   | write command presented on ICB, held until cmd_ready
// ---------------------------------------------------------------------------
module gemm_icb_arbiter #(
  parameter int OUTSTD_DEPTH = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic                            nice_clk,
  input  logic                            nice_rst_n,

  input  logic                            rd_req_valid,
  output logic                            rd_req_ready,
  input  logic [AW-1:0]                   rd_req_addr,
  output logic                            rd_rsp_valid,
  input  logic                            rd_rsp_ready,
  output logic [DW-1:0]                   rd_rsp_data,

  input  logic                            wr_req_valid,
  output logic                            wr_req_ready,
  input  logic [AW-1:0]                   wr_req_addr,
  input  logic [DW-1:0]                   wr_req_data,
  output logic                            wr_done,

  output logic                            nice_icb_cmd_valid,
  input  logic                            nice_icb_cmd_ready,
  output logic [AW-1:0]                   nice_icb_cmd_addr,
  output logic                            nice_icb_cmd_read,
  output logic [DW-1:0]                   nice_icb_cmd_wdata,
  output logic [1:0]                      nice_icb_cmd_size,

  input  logic                            nice_icb_rsp_valid,
  output logic                            nice_icb_rsp_ready,
  input  logic [DW-1:0]                   nice_icb_rsp_rdata,
  input  logic                            nice_icb_rsp_err,

  output logic                            nice_mem_holdup,
  output logic [$clog2(OUTSTD_DEPTH):0]   outstd_cnt,
  output logic                            err_sticky,
  input  logic                            err_clr
);

  localparam int PW = $clog2(OUTSTD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_cmd_valid;
  logic                    r_cmd_read;
  logic [AW-1:0]           r_cmd_addr;
  logic [DW-1:0]           r_cmd_wdata;

  logic [OUTSTD_DEPTH-1:0] r_tag;
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [CW-1:0]           r_cnt;
  logic                    r_err_sticky;

`ifdef GEMM_ARB_RR_EN
  logic                    r_rr_wr_pri;
`endif

  logic                    w_cmd_hs;
  logic                    w_rsp_hs;
  logic                    w_fifo_empty;
  logic                    w_head_rd;
  logic                    w_rsp_ready;
  logic                    w_pick_rd;
  logic                    w_any_req;
  logic                    w_can_grant;
  logic [CW-1:0]           w_cnt_nxt;

  // -------------------------------------------------------------------------
  // Handshakes and response routing
  // -------------------------------------------------------------------------
  assign w_cmd_hs     = r_cmd_valid & nice_icb_cmd_ready;
  assign w_fifo_empty = (r_cnt == '0);
  assign w_head_rd    = r_tag[r_rptr];

  // With nothing in flight, a stray response is swallowed (ready=1) and
  // has no effect on any state.
  always_comb begin
    rd_rsp_valid = 1'b0;
    wr_done      = 1'b0;
    w_rsp_ready  = 1'b1;
    if (!w_fifo_empty) begin
      if (w_head_rd) begin
        rd_rsp_valid = nice_icb_rsp_valid;
        w_rsp_ready  = rd_rsp_ready;
      end else begin
        wr_done      = nice_icb_rsp_valid;
      end
    end
  end

  assign w_rsp_hs = nice_icb_rsp_valid & w_rsp_ready & ~w_fifo_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_cmd_hs && !w_rsp_hs) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_cmd_hs && w_rsp_hs) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // Arbitration uses the count after this cycle's response handshake.
  // This lets a slot freed by a response be re-granted in the same cycle.
  assign w_can_grant = (w_cnt_nxt != CW'(OUTSTD_DEPTH));
  assign w_any_req   = rd_req_valid | wr_req_valid;

`ifdef GEMM_ARB_RR_EN
  assign w_pick_rd = rd_req_valid & (~wr_req_valid | ~r_rr_wr_pri);
`else
  assign w_pick_rd = rd_req_valid & ~wr_req_valid;
`endif

  // -------------------------------------------------------------------------
  // Grant FSM with registered ICB command
  // -------------------------------------------------------------------------
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      r_state     <= S_NONE;
      r_cmd_valid <= 1'b0;
      r_cmd_read  <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
`ifdef GEMM_ARB_RR_EN
      r_rr_wr_pri <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_NONE: begin
          if (w_any_req && w_can_grant) begin
            r_cmd_valid <= 1'b1;
            r_cmd_read  <= w_pick_rd;
            if (w_pick_rd) begin
              r_state     <= S_RD;
              r_cmd_addr  <= rd_req_addr;
              r_cmd_wdata <= '0;
            end else begin
              r_state     <= S_WR;
              r_cmd_addr  <= wr_req_addr;
              r_cmd_wdata <= wr_req_data;
            end
`ifdef GEMM_ARB_RR_EN
            r_rr_wr_pri <= w_pick_rd;
`endif
          end
        end
        S_RD, S_WR: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_NONE;
          end
        end
        default: begin
          r_cmd_valid <= 1'b0;
          r_state     <= S_NONE;
        end
      endcase
    end
  end

  // Requester ready is the command handshake itself, so the requester can
  // drop or advance its request on the very next cycle.
  assign rd_req_ready = (r_state == S_RD) & w_cmd_hs;
  assign wr_req_ready = (r_state == S_WR) & w_cmd_hs;

  // -------------------------------------------------------------------------
  // Tag FIFO and in-flight counter
  // -------------------------------------------------------------------------
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      r_tag  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_tag[r_wptr] <= r_cmd_read;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_rsp_hs) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error: a new error wins over a same-cycle clear
  // -------------------------------------------------------------------------
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_rsp_hs && nice_icb_rsp_err) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign nice_icb_cmd_valid = r_cmd_valid;
  assign nice_icb_cmd_addr  = r_cmd_addr;
  assign nice_icb_cmd_read  = r_cmd_read;
  assign nice_icb_cmd_wdata = r_cmd_wdata;
  assign nice_icb_cmd_size  = 2'b10;
  assign nice_icb_rsp_ready = w_rsp_ready;
  assign rd_rsp_data        = nice_icb_rsp_rdata;
  assign nice_mem_holdup    = r_cmd_valid | (r_cnt != '0);
  assign outstd_cnt         = r_cnt;
  assign err_sticky         = r_err_sticky;

endmodule

// File: tb/tb_gemm_icb_arbiter.sv
module tb_gemm_icb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [31:0] rd_rsp_data;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_addr, wr_req_data;
  logic        wr_done;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        holdup;
  logic [2:0]  outstd_cnt;
  logic        err_sticky, err_clr;

  gemm_icb_arbiter #(.OUTSTD_DEPTH(4), .AW(32), .DW(32)) dut (
    .nice_clk           (clk),
    .nice_rst_n         (rst_n),
    .rd_req_valid       (rd_req_valid),
    .rd_req_ready       (rd_req_ready),
    .rd_req_addr        (rd_req_addr),
    .rd_rsp_valid       (rd_rsp_valid),
    .rd_rsp_ready       (rd_rsp_ready),
    .rd_rsp_data        (rd_rsp_data),
    .wr_req_valid       (wr_req_valid),
    .wr_req_ready       (wr_req_ready),
    .wr_req_addr        (wr_req_addr),
    .wr_req_data        (wr_req_data),
    .wr_done            (wr_done),
    .nice_icb_cmd_valid (cmd_valid),
    .nice_icb_cmd_ready (cmd_ready),
    .nice_icb_cmd_addr  (cmd_addr),
    .nice_icb_cmd_read  (cmd_read),
    .nice_icb_cmd_wdata (cmd_wdata),
    .nice_icb_cmd_size  (cmd_size),
    .nice_icb_rsp_valid (rsp_valid),
    .nice_icb_rsp_ready (rsp_ready),
    .nice_icb_rsp_rdata (rsp_rdata),
    .nice_icb_rsp_err   (rsp_err),
    .nice_mem_holdup    (holdup),
    .outstd_cnt         (outstd_cnt),
    .err_sticky         (err_sticky),
    .err_clr            (err_clr)
  );

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t        q_cmd[$];
  logic [31:0] q_rd[$];
  int          q_wr[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_wr_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic rd, input logic [31:0] addr, input logic [31:0] data);
    cmd_t e;
    e.rd = rd; e.addr = addr; e.data = data;
    q_cmd.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_valid"},   32'(cmd_valid),    32'd0);
    chk({tag, "_rd_req_rdy"},  32'(rd_req_ready), 32'd0);
    chk({tag, "_wr_req_rdy"},  32'(wr_req_ready), 32'd0);
    chk({tag, "_rd_rsp_vld"},  32'(rd_rsp_valid), 32'd0);
    chk({tag, "_wr_done"},     32'(wr_done),      32'd0);
    chk({tag, "_holdup"},      32'(holdup),       32'd0);
    chk({tag, "_outstd_cnt"},  32'(outstd_cnt),   32'd0);
    chk({tag, "_err_sticky"},  32'(err_sticky),   32'd0);
  endtask

  task automatic rd_req(input logic [31:0] addr);
    logic ok = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr  = addr;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rd_req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    chk("rd_req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wr_req(input logic [31:0] addr, input logic [31:0] data);
    logic ok = 1'b0;
    wr_req_valid = 1'b1;
    wr_req_addr  = addr;
    wr_req_data  = data;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (wr_req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
    chk("wr_req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic icb_rsp(input logic [31:0] data, input logic err);
    logic ok = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = data;
    rsp_err   = err;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    chk("icb_rsp_accepted", 32'(ok), 32'd1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        chk("cmd_expected", 32'(q_cmd.size() != 0), 32'd1);
        if (q_cmd.size() != 0) begin
          cmd_t e;
          e = q_cmd.pop_front();
          chk("cmd_read", 32'(cmd_read), 32'(e.rd));
          chk("cmd_addr", cmd_addr, e.addr);
          chk("cmd_size", 32'(cmd_size), 32'd2);
          if (!e.rd) chk("cmd_wdata", cmd_wdata, e.data);
        end
      end
      if (rd_rsp_valid && rd_rsp_ready) begin
        chk("rd_rsp_expected", 32'(q_rd.size() != 0), 32'd1);
        if (q_rd.size() != 0) chk("rd_rsp_data", rd_rsp_data, q_rd.pop_front());
      end
      if (wr_done) begin
        n_wr_done++;
        chk("wr_done_expected", 32'(q_wr.size() != 0), 32'd1);
        if (q_wr.size() != 0) void'(q_wr.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rd_req_valid = 0; rd_req_addr = 0; rd_rsp_ready = 1;
    wr_req_valid = 0; wr_req_addr = 0; wr_req_data = 0;
    cmd_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("por");
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a burst of reads
    push_cmd(1'b1, 32'h8000_0010, 32'h0);
    push_cmd(1'b1, 32'h8000_0010, 32'h0);
    rd_req_addr  = 32'h8000_0010;
    rd_req_valid = 1'b1;
    repeat (5) tick();
    cmd_ready = 1'b0;
    chk("burst_cnt", 32'(outstd_cnt), 32'd2);
    chk("burst_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("burst_holdup", 32'(holdup), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_async");
    rd_req_valid = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_edge");
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    tick();

    // Simultaneous read and write requesters
`ifdef GEMM_ARB_RR_EN
    push_cmd(1'b1, 32'h8000_0400, 32'h0);
    push_cmd(1'b0, 32'h8000_0500, 32'hB0B0_0000);
    push_cmd(1'b1, 32'h8000_0404, 32'h0);
    push_cmd(1'b0, 32'h8000_0504, 32'hB0B0_0001);
`else
    push_cmd(1'b0, 32'h8000_0500, 32'hB0B0_0000);
    push_cmd(1'b0, 32'h8000_0504, 32'hB0B0_0001);
    push_cmd(1'b1, 32'h8000_0400, 32'h0);
    push_cmd(1'b1, 32'h8000_0404, 32'h0);
`endif
    fork
      begin rd_req(32'h8000_0400); rd_req(32'h8000_0404); end
      begin wr_req(32'h8000_0500, 32'hB0B0_0000); wr_req(32'h8000_0504, 32'hB0B0_0001); end
    join
    chk("mix_cnt_full", 32'(outstd_cnt), 32'd4);
    chk("mix_holdup", 32'(holdup), 32'd1);
    chk("mix_no_cmd", 32'(cmd_valid), 32'd0);
    q_rd.push_back(32'hA0A0_0000);
    q_rd.push_back(32'hA0A0_0001);
    q_wr.push_back(0);
    q_wr.push_back(1);
`ifdef GEMM_ARB_RR_EN
    icb_rsp(32'hA0A0_0000, 1'b0);
    icb_rsp(32'h0, 1'b0);
    icb_rsp(32'hA0A0_0001, 1'b0);
    icb_rsp(32'h0, 1'b0);
`else
    icb_rsp(32'h0, 1'b0);
    icb_rsp(32'h0, 1'b0);
    icb_rsp(32'hA0A0_0000, 1'b0);
    icb_rsp(32'hA0A0_0001, 1'b0);
`endif
    chk("mix_cnt_drained", 32'(outstd_cnt), 32'd0);

    // Single read
    push_cmd(1'b1, 32'h8000_0100, 32'h0);
    q_rd.push_back(32'hDEAD_BEEF);
    rd_req(32'h8000_0100);
    chk("single_holdup_busy", 32'(holdup), 32'd1);
    repeat (2) tick();
    icb_rsp(32'hDEAD_BEEF, 1'b0);
    chk("single_holdup_low", 32'(holdup), 32'd0);
    chk("single_cnt", 32'(outstd_cnt), 32'd0);

    // Five reads with responses withheld: the fifth waits for a free slot
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 32'h8000_1000 + 32'(4 * i), 32'h0);
      q_rd.push_back(32'h1111_0000 + 32'(i));
    end
    fork
      begin
        for (int i = 0; i < 5; i++) rd_req(32'h8000_1000 + 32'(4 * i));
      end
      begin
        repeat (16) tick();
        chk("full_cnt", 32'(outstd_cnt), 32'd4);
        chk("full_no_cmd", 32'(cmd_valid), 32'd0);
        chk("full_holdup", 32'(holdup), 32'd1);
        icb_rsp(32'h1111_0000, 1'b0);
        chk("full_fifth_cmd", 32'(cmd_valid), 32'd1);
        chk("full_fifth_ready", 32'(rd_req_ready), 32'd1);
        for (int i = 1; i < 5; i++) icb_rsp(32'h1111_0000 + 32'(i), 1'b0);
      end
    join
    chk("full_cnt_drained", 32'(outstd_cnt), 32'd0);

    // Write then read; read response stalled by the fetch side
    push_cmd(1'b0, 32'h8000_0200, 32'h0000_1234);
    push_cmd(1'b1, 32'h8000_0204, 32'h0);
    q_wr.push_back(2);
    q_rd.push_back(32'hCAFE_F00D);
    wr_req(32'h8000_0200, 32'h0000_1234);
    rd_req(32'h8000_0204);
    chk("wr_rd_cnt", 32'(outstd_cnt), 32'd2);
    icb_rsp(32'h0, 1'b0);
    chk("wr_rsp_cnt", 32'(outstd_cnt), 32'd1);
    rd_rsp_ready = 1'b0;
    rsp_valid    = 1'b1;
    rsp_rdata    = 32'hCAFE_F00D;
    @(negedge clk);
    chk("stall_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("stall_rd_valid", 32'(rd_rsp_valid), 32'd1);
    chk("stall_rd_data", rd_rsp_data, 32'hCAFE_F00D);
    tick();
    chk("stall_cnt", 32'(outstd_cnt), 32'd1);
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("unstall_rsp_ready", 32'(rsp_ready), 32'd1);
    tick();
    rsp_valid = 1'b0;
    chk("unstall_cnt", 32'(outstd_cnt), 32'd0);

    // Sticky error behaviour
    push_cmd(1'b0, 32'h8000_0300, 32'h0000_0055);
    q_wr.push_back(3);
    wr_req(32'h8000_0300, 32'h0000_0055);
    icb_rsp(32'h0, 1'b1);
    chk("err_set", 32'(err_sticky), 32'd1);
    repeat (3) tick();
    chk("err_hold", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_sticky), 32'd0);
    push_cmd(1'b0, 32'h8000_0304, 32'h0000_0066);
    q_wr.push_back(4);
    wr_req(32'h8000_0304, 32'h0000_0066);
    err_clr = 1'b1;
    icb_rsp(32'h0, 1'b1);
    err_clr = 1'b0;
    chk("err_set_wins", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", 32'(err_sticky), 32'd0);

    repeat (2) tick();
    chk("end_cmd_q_empty", 32'(q_cmd.size()), 32'd0);
    chk("end_rd_q_empty", 32'(q_rd.size()), 32'd0);
    chk("end_wr_q_empty", 32'(q_wr.size()), 32'd0);
    chk("end_wr_done_pulses", 32'(n_wr_done), 32'd5);
    chk("end_holdup", 32'(holdup), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
